// File: rtl/fifo_sched.sv
// fifo_sched: write/read controller for one shared first-word-fall-through FIFO.
//
// Write side: round-robin arbitration between two valid/ready producers
// (s0, s1) onto the FIFO write port. Read side: pops the FIFO head into a
// one-entry registered valid/ready output stage (m_*). A flush request
// discards everything queued and pulses flush_done when the FIFO is empty.
// Two statistics counters track words written to the FIFO and words
// delivered to the consumer.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   s0_valid/s0_data/s0_ready  producer 0
//   s1_valid/s1_data/s1_ready  producer 1
//   m_valid/m_data/m_ready     consumer output stage
//   flush, flush_done          flush request / one-cycle completion pulse
//   fifo_write_e, fifo_wdata   FIFO write port
//   fifo_read_e, fifo_rdata    FIFO pop enable / head word
//   fifo_full/empty/ready      FIFO status
//   words_in, words_out        wrapping statistics counters
module fifo_sched #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s0_valid,
    input  logic [DATA_WIDTH-1:0] s0_data,
    output logic                  s0_ready,

    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_ready,

    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,

    input  logic                  flush,
    output logic                  flush_done,

    output logic                  fifo_write_e,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_read_e,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic                  fifo_ready,

    output logic [CNT_WIDTH-1:0]  words_in,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]            state_q,      state_d;
    logic                  rr_prio_q,    rr_prio_d;
    logic                  m_valid_q,    m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
    logic [CNT_WIDTH-1:0]  words_in_q,   words_in_d;
    logic [CNT_WIDTH-1:0]  words_out_q,  words_out_d;
    logic                  flush_done_q, flush_done_d;
    logic                  rd_inflight_q, rd_inflight_d;

    logic in_run;
    logic can_wr;
    logic gnt0;
    logic gnt1;
    logic pop;
    logic drain;
    logic read_e;
    logic handshake;

    // Arbitration and pop decisions. Gating with reset keeps every
    // FIFO-facing strobe low while the FIFO itself is held in reset.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        can_wr    = reset & in_run & fifo_ready & ~fifo_full;
        gnt0      = can_wr & s0_valid & (~rr_prio_q | ~s1_valid);
        gnt1      = can_wr & s1_valid & ( rr_prio_q | ~s0_valid);
        pop       = reset & fifo_ready & ~fifo_empty & (~m_valid_q | m_ready);
        drain     = reset & fifo_ready & ~fifo_empty;
        read_e    = in_run ? pop : drain;
        handshake = m_valid_q & m_ready;
    end

    always_comb begin
        state_d       = state_q;
        rr_prio_d     = rr_prio_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        words_in_d    = words_in_q;
        words_out_d   = words_out_q;
        flush_done_d  = 1'b0;
        rd_inflight_d = read_e;

        if (gnt0 | gnt1) begin
            // Priority passes to the source that was not just served.
            rr_prio_d  = gnt0;
            words_in_d = words_in_q + 1'b1;
        end

        if (handshake) begin
            words_out_d = words_out_q + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d   = ST_FLUSH;
                    m_valid_d = 1'b0;
                end else if (pop) begin
                    m_valid_d = 1'b1;
                    m_data_d  = fifo_rdata;
                end else if (handshake) begin
                    m_valid_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                m_valid_d = 1'b0;
                // Wait one extra cycle after the last pop so the FIFO
                // status reflects it before declaring the flush done.
                if (fifo_empty & fifo_ready & ~rd_inflight_q) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_RUN;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            rr_prio_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            words_in_q    <= '0;
            words_out_q   <= '0;
            flush_done_q  <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_prio_q     <= rr_prio_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            words_in_q    <= words_in_d;
            words_out_q   <= words_out_d;
            flush_done_q  <= flush_done_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    always_comb begin
        s0_ready     = gnt0;
        s1_ready     = gnt1;
        fifo_write_e = gnt0 | gnt1;
        fifo_read_e  = read_e;
        if (gnt0) begin
            fifo_wdata = s0_data;
        end else if (gnt1) begin
            fifo_wdata = s1_data;
        end else begin
            fifo_wdata = '0;
        end
        m_valid    = m_valid_q;
        m_data     = m_data_q;
        flush_done = flush_done_q;
        words_in   = words_in_q;
        words_out  = words_out_q;
    end

endmodule

// File: tb/tb_fifo_sched.sv
// Testbench for fifo_sched: a depth-11 FWFT FIFO model as environment,
// a table of single-cycle arbitration vectors, directed multi-cycle
// sequences and a randomized run checked against a queue-based model.
module tb_fifo_sched;

    localparam int DW    = 128;
    localparam int CW    = 32;
    localparam int DEPTH = 11;

    logic          clk;
    logic          reset;
    logic          s0_valid, s1_valid, m_ready, flush;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_ready, s1_ready, m_valid, flush_done;
    logic [DW-1:0] m_data, fifo_wdata, fifo_rdata;
    logic          fifo_write_e, fifo_read_e;
    logic          fifo_full, fifo_empty, fifo_ready;
    logic [CW-1:0] words_in, words_out;

    // Environment FIFO model (registered status, drops ready for one
    // cycle after a simultaneous write and pop).
    logic [DW-1:0] fmem [0:DEPTH-1];
    int            fwp, frp, fcnt;
    logic          fbusy;

    // Direct drive of FIFO status for the single-cycle vector table.
    logic dir_mode, d_full, d_empty, d_ready;

    assign fifo_rdata = fmem[frp];
    assign fifo_full  = dir_mode ? d_full  : (fcnt == DEPTH);
    assign fifo_empty = dir_mode ? d_empty : (fcnt == 0);
    assign fifo_ready = dir_mode ? d_ready : ~fbusy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwp   <= 0;
            frp   <= 0;
            fcnt  <= 0;
            fbusy <= 1'b0;
        end else begin
            if (fifo_write_e) begin
                fmem[fwp] <= fifo_wdata;
                fwp       <= (fwp + 1) % DEPTH;
            end
            if (fifo_read_e) frp <= (frp + 1) % DEPTH;
            fcnt  <= fcnt + int'(fifo_write_e) - int'(fifo_read_e);
            fbusy <= fifo_write_e & fifo_read_e;
        end
    end

    fifo_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .flush(flush), .flush_done(flush_done),
        .fifo_write_e(fifo_write_e), .fifo_wdata(fifo_wdata),
        .fifo_read_e(fifo_read_e), .fifo_rdata(fifo_rdata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_ready(fifo_ready),
        .words_in(words_in), .words_out(words_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model state.
    logic [DW-1:0] sb[$];
    logic          last_src;     // 1: s1 served last, so s0 wins a tie
    logic          m_full_m;
    logic          in_flush;
    logic          prev_both, prev_hold;
    logic [DW-1:0] prev_md;
    int            n_in, n_out, n_both;
    logic          g0, g1, obs_fd;

    task automatic clear_model();
        sb.delete();
        last_src  = 1'b1;
        m_full_m  = 1'b0;
        in_flush  = 1'b0;
        prev_both = 1'b0;
        prev_hold = 1'b0;
        n_in = 0; n_out = 0; n_both = 0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        s0_valid = 0; s1_valid = 0; m_ready = 0; flush = 0;
        s0_data = '0; s1_data = '0;
        dir_mode = 0; d_full = 0; d_empty = 1; d_ready = 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    // One cycle: inputs already driven at this negedge; check the
    // combinational response, update the model, advance to next negedge.
    task automatic step();
        logic          can, e0, e1, pop_m, hs;
        logic [DW-1:0] ewd;
        #1;
        obs_fd = flush_done;
        g0     = s0_ready;
        g1     = s1_ready;
        if (obs_fd) in_flush = 1'b0;
        can   = !in_flush && fifo_ready && !fifo_full;
        e0    = can && s0_valid && (last_src || !s1_valid);
        e1    = can && s1_valid && (!last_src || !s0_valid);
        pop_m = fifo_ready && !fifo_empty && (in_flush || !m_full_m || m_ready);
        ewd   = e0 ? s0_data : (e1 ? s1_data : '0);
        chk("s0_ready", g0, e0);
        chk("s1_ready", g1, e1);
        chk("fifo_write_e", fifo_write_e, e0 | e1);
        chk("fifo_read_e", fifo_read_e, pop_m);
        chk("fifo_wdata", fifo_wdata, ewd);
        chk("m_valid", m_valid, m_full_m);
        if (!fifo_ready) chk("op_while_busy", fifo_write_e | fifo_read_e, 0);
        if (prev_both) chk("idle_after_both", {fifo_write_e, fifo_read_e}, 0);
        if (prev_hold) chk("m_data_stable", m_data, prev_md);
        hs = m_full_m && m_ready;
        if (hs) begin
            n_out++;
            if (sb.size() == 0) chk("m_data_extra", 1, 0);
            else chk("m_data", m_data, sb.pop_front());
        end
        if (e0) begin sb.push_back(s0_data); n_in++; end
        if (e1) begin sb.push_back(s1_data); n_in++; end
        if (e0 | e1) last_src = e1;
        if (in_flush) m_full_m = 1'b0;
        else if (flush) begin
            m_full_m = 1'b0;
            in_flush = 1'b1;
            sb.delete();
        end else if (pop_m) m_full_m = 1'b1;
        else if (hs) m_full_m = 1'b0;
        prev_both = fifo_write_e & fifo_read_e;
        if (prev_both) n_both++;
        prev_hold = m_valid && !m_ready && !flush && !in_flush;
        prev_md   = m_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        s0_valid = 0; s1_valid = 0; m_ready = 1;
        while ((sb.size() > 0 || m_full_m) && c < bound) begin
            step();
            c++;
        end
        chk("drain_timeout", (sb.size() > 0 || m_full_m), 0);
    endtask

    // Keep valid/data held until accepted; stop offering at lim words.
    task automatic feed_both(input int lim);
        if (g0) s0_data = rnd();
        if (g1) s1_data = rnd();
        s0_valid = (n_in < lim);
        s1_valid = (n_in < lim);
    endtask

    typedef struct {
        logic          s0v, s1v, rdy, full, empty;
        logic          e0, e1, we, re;
        logic [DW-1:0] wd;
    } vec_t;

    localparam logic [DW-1:0] DA = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A1;
    localparam logic [DW-1:0] DB = 128'hB0B0_0000_0000_0000_0000_0000_0000_00B2;

    vec_t tbl [8];
    int   src [16];

    initial begin
        int c, k, pulses;
        logic saw_empty;

        tbl[0] = '{1, 0, 1, 0, 1,  1, 0, 1, 0, DA};
        tbl[1] = '{0, 1, 1, 0, 1,  0, 1, 1, 0, DB};
        tbl[2] = '{1, 1, 1, 0, 1,  1, 0, 1, 0, DA};
        tbl[3] = '{1, 1, 1, 1, 0,  0, 0, 0, 1, '0};
        tbl[4] = '{1, 1, 0, 0, 0,  0, 0, 0, 0, '0};
        tbl[5] = '{0, 0, 1, 0, 0,  0, 0, 0, 1, '0};
        tbl[6] = '{1, 0, 1, 0, 0,  1, 0, 1, 1, DA};
        tbl[7] = '{0, 0, 1, 0, 1,  0, 0, 0, 0, '0};

        // Reset state and idle.
        reset_dut();
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_write_e", fifo_write_e, 0);
        chk("rst_read_e", fifo_read_e, 0);
        chk("rst_words_in", words_in, 0);
        chk("rst_words_out", words_out, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        @(negedge clk);

        // Single-cycle arbitration table from reset state (rr_prio=0,
        // output stage empty); inputs are withdrawn before the edge.
        for (int i = 0; i < 8; i++) begin
            dir_mode = 1; m_ready = 1;
            s0_valid = tbl[i].s0v; s1_valid = tbl[i].s1v;
            s0_data = DA; s1_data = DB;
            d_ready = tbl[i].rdy; d_full = tbl[i].full; d_empty = tbl[i].empty;
            #1;
            chk($sformatf("tbl%0d_s0_ready", i), s0_ready, tbl[i].e0);
            chk($sformatf("tbl%0d_s1_ready", i), s1_ready, tbl[i].e1);
            chk($sformatf("tbl%0d_write_e", i), fifo_write_e, tbl[i].we);
            chk($sformatf("tbl%0d_read_e", i), fifo_read_e, tbl[i].re);
            chk($sformatf("tbl%0d_wdata", i), fifo_wdata, tbl[i].wd);
            #1;
            s0_valid = 0; s1_valid = 0; dir_mode = 0;
            @(negedge clk);
        end

        // s0 alone, five words, consumer always ready.
        reset_dut();
        m_ready = 1; s0_data = rnd(); c = 0;
        while (n_in < 5 && c < 50) begin
            s0_valid = 1;
            step();
            if (g0) s0_data = rnd();
            c++;
        end
        drain(50);
        chk("s0_words_in", words_in, 5);
        chk("s0_words_out", words_out, 5);

        // Both producers contend: grants alternate starting with s0.
        reset_dut();
        m_ready = 0; s0_data = rnd(); s1_data = rnd(); k = 0; c = 0;
        s0_valid = 1; s1_valid = 1;
        while (n_in < 8 && c < 40) begin
            step();
            if (g0 && k < 16) begin src[k] = 0; k++; end
            if (g1 && k < 16) begin src[k] = 1; k++; end
            feed_both(8);
            c++;
        end
        chk("rr_count", k, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_src%0d", i), src[i], i % 2);
        drain(60);
        chk("rr_words_out", words_out, 8);

        // Consumer stalled: FIFO fills (11 + 1 in output stage), then drains.
        reset_dut();
        m_ready = 0; s0_data = rnd(); s1_data = rnd();
        s0_valid = 1; s1_valid = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            feed_both(20);
        end
        chk("full_words_in", words_in, DEPTH + 1);
        chk("full_flag", fifo_full, 1);
        chk("full_no_grant", g0 | g1, 0);
        m_ready = 1; c = 0;
        while (n_in < 20 && c < 200) begin
            step();
            feed_both(20);
            c++;
        end
        drain(100);
        chk("full_words_in_end", words_in, 20);
        chk("full_words_out_end", words_out, 20);

        // Concurrent stream of 50 words.
        reset_dut();
        m_ready = 1; s0_data = rnd(); c = 0;
        while (n_in < 50 && c < 300) begin
            s0_valid = 1;
            step();
            if (g0) s0_data = rnd();
            c++;
        end
        drain(100);
        chk("stream_overlap_seen", n_both > 0, 1);
        chk("stream_words_in", words_in, 50);
        chk("stream_words_out", words_out, 50);

        // Flush with 7 words loaded.
        reset_dut();
        m_ready = 0; s0_data = rnd(); c = 0;
        while (n_in < 7 && c < 40) begin
            s0_valid = 1;
            step();
            if (g0) s0_data = rnd();
            c++;
        end
        s0_valid = 0;
        step();
        chk("pre_flush_m_valid", m_valid, 1);
        flush = 1;
        step();
        flush = 0;
        chk("flush_m_valid_drop", m_valid, 0);
        pulses = 0; saw_empty = 0; c = 0;
        while (c < 40 && !(pulses > 0 && c > 10)) begin
            step();
            if (obs_fd) begin
                pulses++;
                saw_empty = fifo_empty;
            end
            c++;
        end
        chk("flush_pulses", pulses, 1);
        chk("flush_empty_at_done", saw_empty, 1);
        chk("flush_words_out", words_out, 0);
        s1_valid = 1; s1_data = rnd(); m_ready = 1; c = 0;
        while (n_in < 8 && c < 20) begin
            step();
            c++;
        end
        drain(20);
        chk("post_flush_words_in", words_in, 8);
        chk("post_flush_words_out", words_out, 1);

        // Flush into an empty FIFO: one cycle in FLUSH, then the pulse.
        reset_dut();
        flush = 1;
        step();
        flush = 0;
        step();
        chk("eflush_fd0", obs_fd, 0);
        step();
        chk("eflush_fd1", obs_fd, 1);
        step();
        chk("eflush_fd2", obs_fd, 0);

        // Randomized traffic, with an asynchronous reset mid-run.
        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            s0_data = rnd(); s1_data = rnd();
            for (int i = 0; i < 400; i++) begin
                m_ready = ($urandom_range(0, 9) < 7);
                step();
                if (g0 || !s0_valid) begin s0_valid = $urandom_range(0, 1); s0_data = rnd(); end
                if (g1 || !s1_valid) begin s1_valid = $urandom_range(0, 1); s1_data = rnd(); end
            end
            if (pass == 0) begin
                s0_valid = 1; s1_valid = 1; m_ready = 1;
                reset = 0;
                #1;
                chk("async_m_valid", m_valid, 0);
                chk("async_m_data", m_data, 0);
                chk("async_words_in", words_in, 0);
                chk("async_words_out", words_out, 0);
                chk("async_flush_done", flush_done, 0);
                chk("async_strobes", {s0_ready, s1_ready, fifo_write_e, fifo_read_e}, 0);
            end else begin
                drain(200);
                chk("rand_words_in", words_in, n_in);
                chk("rand_words_out", words_out, n_out);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sched.md
Name: fifo_sched

Overview:
- Controller that owns the write and read ports of one shared `fifo` instance (DATA_WIDTH words, first-word-fall-through head on fifo_rdata).
- Write side: round-robin arbitration between two valid/ready producers (s0, s1), e.g. the key path and the data-block path ahead of the AES core.
- Read side: drains the FIFO into a one-entry registered valid/ready output stage for the consumer.
- Adds a flush sequence and word-in/word-out statistics counters.

Parameters:
- DATA_WIDTH, 128, width of FIFO words and of every data port.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s0_valid  in  1  producer 0 word valid.
- s0_data  in  DATA_WIDTH  producer 0 word.
- s0_ready  out  1  producer 0 word accepted this cycle.
- s1_valid, s1_data, s1_ready  same as s0, for producer 1.
- m_valid  out  1  output register holds a word.
- m_data  out  DATA_WIDTH  output word.
- m_ready  in  1  consumer accepts m_data.
- flush  in  1  single-cycle request to discard all FIFO contents.
- flush_done  out  1  one-cycle pulse when the flush completes.
- fifo_write_e  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_read_e  out  1  FIFO pop enable.
- fifo_rdata  in  DATA_WIDTH  FIFO head word.
- fifo_full, fifo_empty, fifo_ready  in  1  FIFO status.
- words_in  out  CNT_WIDTH  count of words written to the FIFO.
- words_out  out  CNT_WIDTH  count of words delivered on m_*.

Behaviour:
- Reset (reset=0, asynchronous):
  - State RUN; rr_prio=0; m_valid=0; m_data=0.
  - words_in=0; words_out=0; flush_done=0.
  - The FIFO must be reset by the same reset.
- fifo_write_e, fifo_read_e, fifo_wdata and s*_ready are combinational from registered state and inputs.

- Write arbitration:
  - can_wr = (state==RUN) & fifo_ready & ~fifo_full.
  - Grant s0 when can_wr & s0_valid & (rr_prio==0 | ~s1_valid).
  - Grant s1 when can_wr & s1_valid & (rr_prio==1 | ~s0_valid).
  - At most one grant per cycle.
  - s*_ready = that source's grant. fifo_write_e = any grant. fifo_wdata = granted source's data, otherwise 0.
  - On a grant, rr_prio becomes the other source; with no grant it holds.
  - words_in increments on each write and wraps modulo 2^CNT_WIDTH.

- Read / output stage:
  - pop = fifo_ready & ~fifo_empty & (~m_valid | m_ready).
  - In RUN, fifo_read_e = pop. On the same edge, m_data <= fifo_rdata and m_valid <= 1.
  - When m_valid & m_ready & ~pop, m_valid <= 0.
  - words_out increments on every cycle with m_valid & m_ready.
  - Back-to-back pops are allowed: the head updates by the next cycle.
  - Latency: a word written at edge N can appear on m_data at edge N+1 at the earliest.

- Simultaneous write and pop in one cycle is permitted.
  - The FIFO then drops fifo_ready for one cycle.
  - In that cycle neither fifo_write_e nor fifo_read_e may assert, and all s*_ready=0.
  - An operation is never issued while fifo_ready=0.

- FSM:
  - RUN -> FLUSH on flush=1.
    - The output register is cleared on entry: m_valid <= 0, and any pending m word is discarded.
  - FLUSH:
    - No grants.
    - fifo_read_e = fifo_ready & ~fifo_empty. Popped data is discarded; words_out does not count it.
    - m_valid stays 0.
  - FLUSH -> RUN when fifo_empty=1 and no pop is in flight; flush_done=1 for exactly that one cycle.
  - A flush that arrives while already in FLUSH is ignored.
  - A flush into an already empty FIFO takes one cycle in FLUSH, then flush_done pulses.

- Boundary cases:
  - Full: no grants. A pop in the same cycle frees a slot from the next cycle.
  - Empty: no pop. m_valid drops after the consumer takes the last word.
  - m_ready=0 with m_valid=1: m_data holds stable and no pop occurs.
  - Reset asserted mid-transfer: all outputs return immediately to their reset values.

Test Plan:
- Reset then idle: m_valid=0, fifo_write_e=0, fifo_read_e=0, words_in=words_out=0; fifo_empty=1 observed.
- s0 alone sends 5 random words with m_ready=1: they emerge in order on m_data, words_in=5, words_out=5, no write issued while fifo_ready=0.
- s0 and s1 both hold valid for 8 cycles into a FIFO of DEPTH 11: grants alternate s0,s1,s0,...; 4 words from each stored, FIFO order matches grant order.
- m_ready=0 while producers push 20 words: writes stop when fifo_full=1 (11 words); then m_ready=1 drains all 11 in order; s*_ready resumes when not full; no word lost or duplicated.
- Concurrent stream, 50 words with m_ready=1 and s0_valid=1 every cycle: after every simultaneous write and pop, the next cycle shows fifo_write_e=0 and fifo_read_e=0; final words_in = words_out = 50.
- Load 7 words, m_valid=1, assert flush one cycle: m_valid drops next cycle, FIFO popped until empty, flush_done pulses once, words_out unchanged, new s1 word then accepted and delivered.
